// File: rtl/inta_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : inta_sequencer_if
// Description : Bundle of signals between the CPU/ICW/priority-resolver side
//               and the interrupt-acknowledge sequencer.
//   CPU       : inta_n
//   ICW regs  : mode_8086, auto_eoi, vector_base, call_hi, call_lo_base,
//               interval4
//   Resolver  : irq_valid, irq_level (in); freeze, ack_pulse, ack_level,
//               aeoi_pulse (out)
//   Data buf  : data_out, data_oe (out)
// Revision    : 1.0 - initial release
// ============================================================================
interface inta_sequencer_if;
   logic       inta_n;
   logic       mode_8086;
   logic       auto_eoi;
   logic [4:0] vector_base;
   logic [7:0] call_hi;
   logic [2:0] call_lo_base;
   logic       interval4;
   logic       irq_valid;
   logic [2:0] irq_level;
   logic [7:0] data_out;
   logic       data_oe;
   logic       freeze;
   logic       ack_pulse;
   logic [2:0] ack_level;
   logic       aeoi_pulse;

   // Sequencer side
   modport slave (
      input  inta_n, mode_8086, auto_eoi, vector_base, call_hi,
             call_lo_base, interval4, irq_valid, irq_level,
      output data_out, data_oe, freeze, ack_pulse, ack_level, aeoi_pulse
   );

   // Environment side (CPU, ICW registers, priority resolver, data buffer)
   modport master (
      output inta_n, mode_8086, auto_eoi, vector_base, call_hi,
             call_lo_base, interval4, irq_valid, irq_level,
      input  data_out, data_oe, freeze, ack_pulse, ack_level, aeoi_pulse
   );
endinterface
`default_nettype wire

// File: rtl/inta_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : inta_sequencer
// Description : Interrupt-acknowledge sequencer for an 8259-style controller.
//               Follows the CPU INTA strobes, freezes the priority resolver,
//               issues the ISR/IRR acknowledge pulse, drives the vector or
//               CALL bytes onto the data buffer and optionally issues an
//               automatic EOI at the end of the sequence.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset
//               bus   - inta_sequencer_if.slave (INTA strobe, ICW fields,
//                       resolver request in; data byte/enable, freeze,
//                       ack/aeoi pulses and ack level out)
// Revision    : 1.0 - initial release
// ============================================================================
module inta_sequencer (
   input  logic              clk,
   input  logic              rst_n,
   inta_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_P1   = 3'd1,
      S_G1   = 3'd2,
      S_P2   = 3'd3,
      S_G2   = 3'd4,
      S_P3   = 3'd5
   } state_t;

   localparam logic [7:0] C_CALL_OPCODE = 8'hCD;
   localparam logic [2:0] C_SPURIOUS_LEVEL = 3'd7;

   // ------------------------------------------------------------------------
   // INTA synchronizer and edge detection
   // ------------------------------------------------------------------------
   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic w_fall;
   logic w_rise;

   // Flops reset to 1 (strobe idle) so an INTA already low at reset
   // release is seen as a fresh falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= bus.inta_n;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_fall = ~r_sync2 &  r_prev;
   assign w_rise =  r_sync2 & ~r_prev;

   // ------------------------------------------------------------------------
   // Sequencer FSM with registered outputs
   // ------------------------------------------------------------------------
   state_t     r_state;
   logic       r_mode_8086;
   logic       r_spurious;
   logic [7:0] r_data_out;
   logic       r_data_oe;
   logic       r_freeze;
   logic       r_ack_pulse;
   logic [2:0] r_ack_level;
   logic       r_aeoi_pulse;

   logic [7:0] w_vector_byte;
   logic [7:0] w_call_lo_byte;

   assign w_vector_byte  = {bus.vector_base, r_ack_level};
   // 4-byte interval keeps all three base bits; 8-byte interval spends
   // A5 on the wider level spacing.
   assign w_call_lo_byte = bus.interval4 ?
                           {bus.call_lo_base, r_ack_level, 2'b00} :
                           {bus.call_lo_base[2:1], r_ack_level, 3'b000};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_mode_8086  <= 1'b0;
         r_spurious   <= 1'b0;
         r_data_out   <= 8'h00;
         r_data_oe    <= 1'b0;
         r_freeze     <= 1'b0;
         r_ack_pulse  <= 1'b0;
         r_ack_level  <= 3'd0;
         r_aeoi_pulse <= 1'b0;
      end else begin
         r_ack_pulse  <= 1'b0;
         r_aeoi_pulse <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_fall) begin
                  r_state     <= S_P1;
                  r_mode_8086 <= bus.mode_8086;
                  r_freeze    <= 1'b1;
                  r_spurious  <= ~bus.irq_valid;
                  r_ack_pulse <= bus.irq_valid;
                  r_ack_level <= bus.irq_valid ? bus.irq_level : C_SPURIOUS_LEVEL;
                  // 8086 first pulse is a dummy cycle; 8080 gets the CALL opcode
                  r_data_oe   <= ~bus.mode_8086;
                  r_data_out  <= bus.mode_8086 ? 8'h00 : C_CALL_OPCODE;
               end
            end

            S_P1: begin
               if (w_rise) begin
                  r_state    <= S_G1;
                  r_data_oe  <= 1'b0;
                  r_data_out <= 8'h00;
               end
            end

            S_G1: begin
               if (w_fall) begin
                  r_state    <= S_P2;
                  r_data_oe  <= 1'b1;
                  r_data_out <= r_mode_8086 ? w_vector_byte : w_call_lo_byte;
               end
            end

            S_P2: begin
               if (w_rise) begin
                  r_data_oe  <= 1'b0;
                  r_data_out <= 8'h00;
                  if (r_mode_8086) begin
                     r_state      <= S_IDLE;
                     r_freeze     <= 1'b0;
                     r_aeoi_pulse <= bus.auto_eoi & ~r_spurious;
                  end else begin
                     r_state <= S_G2;
                  end
               end
            end

            S_G2: begin
               if (w_fall) begin
                  r_state    <= S_P3;
                  r_data_oe  <= 1'b1;
                  r_data_out <= bus.call_hi;
               end
            end

            S_P3: begin
               if (w_rise) begin
                  r_state      <= S_IDLE;
                  r_data_oe    <= 1'b0;
                  r_data_out   <= 8'h00;
                  r_freeze     <= 1'b0;
                  r_aeoi_pulse <= bus.auto_eoi & ~r_spurious;
               end
            end

            default: begin
               r_state    <= S_IDLE;
               r_data_oe  <= 1'b0;
               r_data_out <= 8'h00;
               r_freeze   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_out   = r_data_out;
   assign bus.data_oe    = r_data_oe;
   assign bus.freeze     = r_freeze;
   assign bus.ack_pulse  = r_ack_pulse;
   assign bus.ack_level  = r_ack_level;
   assign bus.aeoi_pulse = r_aeoi_pulse;

endmodule
`default_nettype wire

// File: tb/tb_inta_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_inta_sequencer
// Description : Self-checking bench for inta_sequencer. Stimulus pushes the
//               expected bytes / ack levels / aeoi levels of each INTA
//               sequence into queues; an independent monitor pops and checks
//               them whenever the DUT presents a drive window or a pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inta_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   inta_sequencer_if bus();

   inta_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit       m86;
      bit       valid;
      bit [2:0] lvl;
      bit [4:0] vb;
      bit [7:0] hi;
      bit [2:0] lob;
      bit       i4;
      bit       ae;
   } cfg_t;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] exp_bytes[$];
   logic [2:0] exp_ack[$];
   logic [2:0] exp_aeoi[$];

   // ------------------------------------------------------------------------
   // Reference model: what one whole acknowledge sequence must produce
   // ------------------------------------------------------------------------
   task automatic push_expect(input cfg_t c);
      int lvl;
      int lo;
      lvl = c.valid ? int'(c.lvl) : 7;
      if (c.m86) begin
         exp_bytes.push_back(8'(int'(c.vb) * 8 + lvl));
      end else begin
         if (c.i4) lo = int'(c.lob) * 32 + lvl * 4;
         else      lo = (int'(c.lob) / 2) * 64 + lvl * 8;
         exp_bytes.push_back(8'hCD);
         exp_bytes.push_back(8'(lo));
         exp_bytes.push_back(c.hi);
      end
      if (c.valid) exp_ack.push_back(3'(lvl));
      if (c.valid && c.ae) exp_aeoi.push_back(3'(lvl));
   endtask

   task automatic flush_expect();
      exp_bytes.delete();
      exp_ack.delete();
      exp_aeoi.delete();
   endtask

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Monitor / scoreboard
   // ------------------------------------------------------------------------
   logic       m_prev_oe   = 1'b0;
   logic       m_prev_ack  = 1'b0;
   logic       m_prev_aeoi = 1'b0;
   logic [7:0] m_cur_byte  = 8'h00;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_prev_oe   = 1'b0;
         m_prev_ack  = 1'b0;
         m_prev_aeoi = 1'b0;
      end else begin
         if (bus.data_oe && !m_prev_oe) begin
            n_cmp++;
            if (exp_bytes.size() == 0) begin
               n_fail++;
               $display("FAIL drive_unexpected: data_out=%02h driven, none expected (t=%0t)",
                        bus.data_out, $time);
               m_cur_byte = bus.data_out;
            end else begin
               m_cur_byte = exp_bytes.pop_front();
               if (bus.data_out !== m_cur_byte) begin
                  n_fail++;
                  $display("FAIL drive_byte: data_out=%02h expected %02h (t=%0t)",
                           bus.data_out, m_cur_byte, $time);
               end
            end
         end else if (bus.data_oe) begin
            check("drive_stable", int'(bus.data_out), int'(m_cur_byte));
         end else begin
            check("idle_data_zero", int'(bus.data_out), 0);
         end

         if (bus.ack_pulse) begin
            check("ack_width", int'(m_prev_ack), 0);
            check("ack_freeze", int'(bus.freeze), 1);
            n_cmp++;
            if (exp_ack.size() == 0) begin
               n_fail++;
               $display("FAIL ack_unexpected: ack_pulse with level %0d, none expected (t=%0t)",
                        bus.ack_level, $time);
            end else begin
               check("ack_level", int'(bus.ack_level), int'(exp_ack.pop_front()));
            end
         end

         if (bus.aeoi_pulse) begin
            check("aeoi_width", int'(m_prev_aeoi), 0);
            check("aeoi_freeze", int'(bus.freeze), 0);
            n_cmp++;
            if (exp_aeoi.size() == 0) begin
               n_fail++;
               $display("FAIL aeoi_unexpected: aeoi_pulse with level %0d, none expected (t=%0t)",
                        bus.ack_level, $time);
            end else begin
               check("aeoi_level", int'(bus.ack_level), int'(exp_aeoi.pop_front()));
            end
         end

         m_prev_oe   = bus.data_oe;
         m_prev_ack  = bus.ack_pulse;
         m_prev_aeoi = bus.aeoi_pulse;
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic apply_cfg(input cfg_t c);
      bus.mode_8086    = c.m86;
      bus.irq_valid    = c.valid;
      bus.irq_level    = c.lvl;
      bus.vector_base  = c.vb;
      bus.call_hi      = c.hi;
      bus.call_lo_base = c.lob;
      bus.interval4    = c.i4;
      bus.auto_eoi     = $urandom_range(1, 0);
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_bytes_left"}, exp_bytes.size(), 0);
      check({tag, "_acks_left"},  exp_ack.size(),   0);
      check({tag, "_aeois_left"}, exp_aeoi.size(),  0);
   endtask

   // One full acknowledge sequence. With start_low the strobe is already
   // low when reset releases, which must count as the first falling edge.
   task automatic run_seq(input cfg_t c, input bit start_low);
      int npulse;
      npulse = c.m86 ? 2 : 3;
      apply_cfg(c);
      if (start_low) begin
         rst_n = 1'b0;
         #1;
         bus.inta_n = 1'b0;
         flush_expect();
         push_expect(c);
         wait_cycles(2);
         rst_n = 1'b1;
      end else begin
         push_expect(c);
      end
      for (int p = 0; p < npulse; p++) begin
         if (p == npulse - 1) bus.auto_eoi = c.ae;
         if (!(start_low && p == 0)) bus.inta_n = 1'b0;
         wait_cycles(5);
         if (p == 0) begin
            // latched values must govern; scramble the live inputs
            bus.mode_8086 = $urandom_range(1, 0);
            bus.irq_valid = $urandom_range(1, 0);
            bus.irq_level = 3'($urandom_range(7, 0));
         end
         wait_cycles($urandom_range(4, 1));
         check("freeze_in_pulse", int'(bus.freeze), 1);
         bus.inta_n = 1'b1;
         if (p < npulse - 1) bus.auto_eoi = $urandom_range(1, 0);
         wait_cycles($urandom_range(9, 6));
         if (p < npulse - 1) check("freeze_in_gap", int'(bus.freeze), 1);
      end
      check("freeze_released", int'(bus.freeze), 0);
      check("oe_released", int'(bus.data_oe), 0);
      check_drained("seq");
   endtask

   function automatic cfg_t rand_cfg();
      cfg_t c;
      c.m86   = $urandom_range(1, 0);
      c.valid = ($urandom_range(7, 0) != 0);
      c.lvl   = 3'($urandom_range(7, 0));
      c.vb    = 5'($urandom_range(31, 0));
      c.hi    = 8'($urandom_range(255, 0));
      c.lob   = 3'($urandom_range(7, 0));
      c.i4    = $urandom_range(1, 0);
      c.ae    = $urandom_range(1, 0);
      return c;
   endfunction

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   initial begin
      cfg_t c;
      bus.inta_n = 1'b1;
      apply_cfg(rand_cfg());
      rst_n = 1'b0;
      wait_cycles(3);
      check("rst_data_out",  int'(bus.data_out),   0);
      check("rst_data_oe",   int'(bus.data_oe),    0);
      check("rst_freeze",    int'(bus.freeze),     0);
      check("rst_ack_pulse", int'(bus.ack_pulse),  0);
      check("rst_ack_level", int'(bus.ack_level),  0);
      check("rst_aeoi",      int'(bus.aeoi_pulse), 0);
      rst_n = 1'b1;
      wait_cycles(3);

      // 8086, level 5, vector 0x45, no AEOI
      c = '{m86:1, valid:1, lvl:5, vb:5'b01000, hi:8'h00, lob:3'b000, i4:0, ae:0};
      run_seq(c, 1'b0);
      // 8080, level 3, 4-byte interval -> CD, AC, 12
      c = '{m86:0, valid:1, lvl:3, vb:5'd0, hi:8'h12, lob:3'b101, i4:1, ae:0};
      run_seq(c, 1'b0);
      // 8080, level 6, 8-byte interval -> second byte F0
      c = '{m86:0, valid:1, lvl:6, vb:5'd0, hi:8'h34, lob:3'b110, i4:0, ae:1};
      run_seq(c, 1'b0);
      // spurious 8086 with AEOI requested -> byte 17, no pulses
      c = '{m86:1, valid:0, lvl:2, vb:5'b00010, hi:8'h00, lob:3'b000, i4:0, ae:1};
      run_seq(c, 1'b0);
      // 8086 AEOI on level 2
      c = '{m86:1, valid:1, lvl:2, vb:5'b10101, hi:8'h00, lob:3'b000, i4:0, ae:1};
      run_seq(c, 1'b0);

      // reset during P2 of an 8080 sequence
      c = '{m86:0, valid:1, lvl:4, vb:5'd0, hi:8'h77, lob:3'b011, i4:1, ae:1};
      apply_cfg(c);
      push_expect(c);
      bus.inta_n = 1'b0;
      wait_cycles(7);
      bus.inta_n = 1'b1;
      wait_cycles(7);
      bus.inta_n = 1'b0;
      wait_cycles(7);
      check("p2_oe_before_reset", int'(bus.data_oe), 1);
      #1 rst_n = 1'b0;
      #1;
      check("reset_oe_async",     int'(bus.data_oe),  0);
      check("reset_freeze_async", int'(bus.freeze),   0);
      check("reset_data_async",   int'(bus.data_out), 0);
      flush_expect();
      bus.inta_n = 1'b1;
      wait_cycles(2);
      rst_n = 1'b1;
      wait_cycles(4);
      check("after_reset_aeoi_q", exp_aeoi.size(), 0);
      c.ae = 1'b0;
      run_seq(c, 1'b0);

      // strobe already low at reset release
      c = '{m86:0, valid:1, lvl:1, vb:5'd0, hi:8'hA5, lob:3'b010, i4:0, ae:1};
      run_seq(c, 1'b1);
      c = '{m86:1, valid:1, lvl:7, vb:5'b11111, hi:8'h00, lob:3'b000, i4:1, ae:0};
      run_seq(c, 1'b1);

      for (int i = 0; i < 40; i++) begin
         run_seq(rand_cfg(), 1'b0);
      end

      wait_cycles(5);
      check_drained("final");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, compared=%0d", n_cmp);
      n_fail++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 Parameters: none; all sequencing is fixed by this specification.
REQ-002 clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 inta_n  in  1  CPU interrupt-acknowledge strobe, active-low, asynchronous to clk.
REQ-005 mode_8086  in  1  1 = 8086 sequence of 2 pulses; 0 = 8080 sequence of 3 pulses (ICW4 uPM).
REQ-006 auto_eoi  in  1  1 = issue automatic EOI at sequence end (ICW4 AEOI).
REQ-007 vector_base  in  5  T7..T3 of the vector (ICW2[7:3]), used in 8086 mode.
REQ-008 call_hi  in  8  8080 CALL high address byte (ICW2).
REQ-009 call_lo_base  in  3  8080 address bits A7..A5 (ICW1[7:5]).
REQ-010 interval4  in  1  8080 call interval: 1 = 4 bytes, 0 = 8 bytes (ICW1 ADI).
REQ-011 irq_valid  in  1  priority resolver has a pending, unmasked winning request.
REQ-012 irq_level  in  3  winning IR level; valid when irq_valid=1.
REQ-013 data_out  out  8  byte for the data buffer to drive onto D during an INTA pulse.
REQ-014 data_oe  out  1  data buffer drive enable, the data-buffer "drive D" flag.
REQ-015 freeze  out  1  holds the priority resolver stable for the whole sequence.
REQ-016 ack_pulse  out  1  one-cycle pulse: set ISR[level], clear IRR[level].
REQ-017 ack_level  out  3  latched level accompanying ack_pulse and aeoi_pulse.
REQ-018 aeoi_pulse  out  1  one-cycle pulse: clear ISR[ack_level] (automatic EOI).

Function
REQ-019 inta_n SHALL pass through a 2-flop synchronizer; a third flop holds the previous synced value; a falling edge is synced=0 & prev=1, a rising edge is synced=1 & prev=0.
REQ-020 FSM states SHALL be IDLE, P1, G1, P2, G2, P3; edges move P1->G1 (rise), G1->P2 (fall), P2->G2 (rise, 8080 only), G2->P3 (fall), and P2 (8086) or P3 (8080) -> IDLE on rise.
REQ-021 On a falling edge in IDLE the block SHALL enter P1, latch mode_8086, set freeze=1, and latch ack_level=irq_level, or 3'd7 if irq_valid=0 (spurious).
REQ-022 ack_pulse SHALL assert for exactly the one cycle after the P1 entry edge, and only if irq_valid was 1 at that edge; a spurious sequence produces no ack_pulse.
REQ-023 data_out/data_oe SHALL be registered; data_oe=1 from the cycle after the falling edge that enters a driving state until the cycle after the matching rising edge; data_oe=0 in IDLE, G1 and G2.
REQ-024 8086 mode: P1 SHALL not drive (data_oe=0); P2 SHALL drive {vector_base, ack_level}.
REQ-025 8080 mode: P1 SHALL drive 8'hCD; P2 SHALL drive the low byte; P3 SHALL drive call_hi.
REQ-026 8080 low byte SHALL be {call_lo_base, ack_level, 2'b00} when interval4=1, and {call_lo_base[2:1], ack_level, 3'b000} when interval4=0.
REQ-027 On the final rising edge the block SHALL clear freeze, return to IDLE, and pulse aeoi_pulse for one cycle if auto_eoi=1 and the sequence was not spurious.
REQ-028 mode_8086 and auto_eoi changes SHALL be ignored mid-sequence; the mode latched at P1 and the auto_eoi value at the final edge govern.
REQ-029 When data_oe=0, data_out SHALL be 8'h00.

Reset
REQ-030 While rst_n=0: state=IDLE, all synchronizer flops=1, data_out=8'h00, data_oe=0, freeze=0, ack_pulse=0, ack_level=3'd0, aeoi_pulse=0.
REQ-031 Reset asserted mid-sequence SHALL abort the sequence with no aeoi_pulse and SHALL release data_oe asynchronously.
REQ-032 If inta_n is low at reset release, the block SHALL treat it as a new P1 falling edge 2 cycles later.

Verification
REQ-033 8086, irq_valid=1, level 5, vector_base=5'b01000, auto_eoi=0, two INTA pulses -> one ack_pulse with ack_level=5; data_oe=0 in P1; data_out=8'h45 in P2; freeze cleared after pulse 2; no aeoi_pulse.
REQ-034 8080, level 3, call_lo_base=3'b101, interval4=1, call_hi=8'h12 -> data_out 8'hCD, then 8'hAC, then 8'h12 across three pulses; freeze held through G1 and G2.
REQ-035 8080, interval4=0, level 6, call_lo_base=3'b110 -> second byte 8'hF0.
REQ-036 8086, irq_valid=0 at first falling edge, vector_base=5'b00010 -> no ack_pulse, no aeoi_pulse even with auto_eoi=1, second byte 8'h17.
REQ-037 auto_eoi=1, level 2, 8086 -> aeoi_pulse exactly 1 cycle after the rising edge of pulse 2, with ack_level=2.
REQ-038 rst_n pulsed low during P2 of an 8080 sequence -> data_oe=0 immediately, state IDLE, next INTA pulse starts a new P1 that drives 8'hCD.
